// File: rtl/gate_apply_seq.sv
// Applies a programmable 2x2 complex Q16.16 gate to one amplitude pair, one MAC per cycle.
// Optional macro GATE_ZERO_SKIP_EN skips terms whose coefficient is exactly zero.

module fixed_point_mult #(
   parameter int WIDTH = 32,
   parameter int FRAC  = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y,
   output logic             ovf
);
   logic signed [2*WIDTH-1:0] a_ext_s, b_ext_s, full_s, shifted_s;
   logic [WIDTH:0]            top_s;

   // Full-precision product, rescaled and saturated back to WIDTH bits
   always_comb begin
      a_ext_s   = {{WIDTH{a[WIDTH-1]}}, a};
      b_ext_s   = {{WIDTH{b[WIDTH-1]}}, b};
      full_s    = a_ext_s * b_ext_s;
      shifted_s = full_s >>> FRAC;
      top_s     = shifted_s[2*WIDTH-1:WIDTH-1];
      ovf       = !((&top_s) || !(|top_s));
      if (ovf) begin
         y = shifted_s[2*WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
         y = shifted_s[WIDTH-1:0];
      end
   end
endmodule

module fixed_point_add #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y,
   output logic             ovf
);
   logic [WIDTH:0] sum_s;

   // Saturating signed add
   always_comb begin
      sum_s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
      ovf   = sum_s[WIDTH] ^ sum_s[WIDTH-1];
      if (ovf) begin
         y = sum_s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
         y = sum_s[WIDTH-1:0];
      end
   end
endmodule

module gate_apply_seq #(
   parameter int WIDTH = 32,
   parameter int FRAC  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [2:0]       cfg_addr,
   input  logic [WIDTH-1:0] cfg_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a0_re,
   input  logic [WIDTH-1:0] in_a0_im,
   input  logic [WIDTH-1:0] in_a1_re,
   input  logic [WIDTH-1:0] in_a1_im,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_b0_re,
   output logic [WIDTH-1:0] out_b0_im,
   output logic [WIDTH-1:0] out_b1_re,
   output logic [WIDTH-1:0] out_b1_im,
   output logic             out_ovf,
   output logic             busy
);
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MAC = 2'd1, ST_DONE = 2'd2} state_t;

   localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};
   localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] MIN_C  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] MAX_C  = {1'b0, {(WIDTH-1){1'b1}}};

   state_t           state_r, state_next_s;
   logic [WIDTH-1:0] coef_r  [8];
   logic [WIDTH-1:0] amp_r   [4];
   logic [WIDTH-1:0] out_b_r [4];
   logic [3:0]       step_r;
   logic [WIDTH-1:0] acc_r;
   logic             ovf_r;

   logic             accept_s, neg_s, neg_ovf_s, mult_ovf_s, add_ovf_s;
   logic [1:0]       cur_comp_s;
   logic [WIDTH-1:0] prod_s, term_s, sum_s;
   logic [15:0]      nz_s;
   logic [4:0]       next_s, start_s;
   logic [3:0]       wr_en_s;
   logic [WIDTH-1:0] wr_data_s [4];

   assign accept_s   = in_valid && (state_r == ST_IDLE);
   assign cur_comp_s = step_r[3:2];
   // Coefficient {row, column, imag}; amplitude {column, imag}; re rows subtract the im*im term
   assign neg_s      = !step_r[2] && step_r[0];

   fixed_point_mult #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mult (
      .a   (coef_r[{step_r[3], step_r[1], step_r[0]}]),
      .b   (amp_r[{step_r[1], step_r[0] ^ step_r[2]}]),
      .y   (prod_s),
      .ovf (mult_ovf_s)
   );

   fixed_point_add #(.WIDTH(WIDTH)) u_add (
      .a   (acc_r),
      .b   (term_s),
      .y   (sum_s),
      .ovf (add_ovf_s)
   );

   // Term sign handling; the most negative product saturates when negated
   always_comb begin
      neg_ovf_s = 1'b0;
      if (neg_s) begin
         if (prod_s == MIN_C) begin
            term_s    = MAX_C;
            neg_ovf_s = 1'b1;
         end else begin
            term_s = ZERO_C - prod_s;
         end
      end else begin
         term_s = prod_s;
      end
   end

   // Live-term mask, first live term of a pair and the live term after the current one
   always_comb begin
`ifdef GATE_ZERO_SKIP_EN
      for (int i = 0; i < 16; i++) begin
         nz_s[i] = (coef_r[{i[3], i[1], i[0]}] != ZERO_C);
      end
`else
      nz_s = 16'hFFFF;
`endif
      next_s  = 5'd16;
      start_s = 5'd16;
      for (int i = 15; i >= 0; i--) begin
         if (nz_s[i]) begin
            start_s = 5'(i);
            if (5'(i) > {1'b0, step_r}) begin
               next_s = 5'(i);
            end else begin
               next_s = next_s;
            end
         end else begin
            start_s = start_s;
         end
      end
   end

   // A component is written once the pointer moves past its last term
   always_comb begin
      for (int c = 0; c < 4; c++) begin
         wr_en_s[c]   = 1'b0;
         wr_data_s[c] = ZERO_C;
         if (state_r == ST_MAC) begin
            wr_en_s[c]   = (2'(c) >= cur_comp_s) && ({1'b0, 2'(c), 2'b11} < next_s);
            wr_data_s[c] = (2'(c) == cur_comp_s) ? sum_s : ZERO_C;
         end else if (accept_s) begin
            wr_en_s[c] = ({1'b0, 2'(c), 2'b11} < start_s);
         end else begin
            wr_en_s[c] = 1'b0;
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_next_s = start_s[4] ? ST_DONE : ST_MAC;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_MAC:  state_next_s = next_s[4] ? ST_DONE : ST_MAC;
         ST_DONE: state_next_s = out_ready ? ST_IDLE : ST_DONE;
         default: state_next_s = ST_IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      in_ready  = (state_r == ST_IDLE);
      out_valid = (state_r == ST_DONE);
      busy      = (state_r != ST_IDLE);
      out_ovf   = ovf_r;
      out_b0_re = out_b_r[0];
      out_b0_im = out_b_r[1];
      out_b1_re = out_b_r[2];
      out_b1_im = out_b_r[3];
   end

   // Datapath registers: coefficients, operands, accumulator, results
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) coef_r[i] <= (i == 0 || i == 6) ? ONE_C : ZERO_C;
         for (int i = 0; i < 4; i++) begin
            amp_r[i]   <= ZERO_C;
            out_b_r[i] <= ZERO_C;
         end
         step_r <= 4'd0;
         acc_r  <= ZERO_C;
         ovf_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (cfg_we) coef_r[cfg_addr] <= cfg_data;
               if (accept_s) begin
                  amp_r[0] <= in_a0_re;
                  amp_r[1] <= in_a0_im;
                  amp_r[2] <= in_a1_re;
                  amp_r[3] <= in_a1_im;
                  ovf_r    <= 1'b0;
                  acc_r    <= ZERO_C;
                  step_r   <= start_s[3:0];
               end
            end
            ST_MAC: begin
               ovf_r  <= ovf_r | mult_ovf_s | neg_ovf_s | add_ovf_s;
               step_r <= next_s[3:0];
               acc_r  <= (next_s[4:2] != {1'b0, cur_comp_s}) ? ZERO_C : sum_s;
            end
            ST_DONE: acc_r <= acc_r;
            default: acc_r <= ZERO_C;
         endcase
         for (int c = 0; c < 4; c++) begin
            if (wr_en_s[c]) out_b_r[c] <= wr_data_s[c];
         end
      end
   end
endmodule

// File: tb/tb_gate_apply_seq.sv
// Directed bench for gate_apply_seq (default build: 16 MAC cycles per pair).
module tb_gate_apply_seq;
   logic        clk = 1'b0;
   logic        rst, cfg_we, in_valid, in_ready, out_valid, out_ready, out_ovf, busy;
   logic [2:0]  cfg_addr;
   logic [31:0] cfg_data, in_a0_re, in_a0_im, in_a1_re, in_a1_im;
   logic [31:0] out_b0_re, out_b0_im, out_b1_re, out_b1_im;
   int          tests_run = 0;
   int          tests_failed = 0;
   int          lat;

   gate_apply_seq dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a0_re(in_a0_re), .in_a0_im(in_a0_im), .in_a1_re(in_a1_re), .in_a1_im(in_a1_im),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_b0_re(out_b0_re), .out_b0_im(out_b0_im), .out_b1_re(out_b1_re), .out_b1_im(out_b1_im),
      .out_ovf(out_ovf), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cfg_write(input logic [2:0] addr, input logic [31:0] data);
      cfg_we = 1'b1; cfg_addr = addr; cfg_data = data;
      @(posedge clk); #1;
      cfg_we = 1'b0;
   endtask

   task automatic start_pair(input logic [31:0] a0r, a0i, a1r, a1i);
      check_eq("ready_before_start", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1; in_a0_re = a0r; in_a0_im = a0i; in_a1_re = a1r; in_a1_im = a1i;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Counts edges from acceptance until out_valid; optionally pokes cfg mid-MAC
   task automatic wait_done(input bit poke, output int cycles);
      cycles = 0;
      while (!out_valid && cycles < 40) begin
         @(posedge clk); #1;
         cycles++;
         cfg_we = poke && (cycles == 3);
         cfg_addr = 3'd0; cfg_data = 32'h1234_5678;
      end
      cfg_we = 1'b0;
   endtask

   task automatic check_result(input string tag, input logic [31:0] b0r, b0i, b1r, b1i,
                               input logic ovf);
      check_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      check_eq({tag, "_b0_re"}, out_b0_re, b0r);
      check_eq({tag, "_b0_im"}, out_b0_im, b0i);
      check_eq({tag, "_b1_re"}, out_b1_re, b1r);
      check_eq({tag, "_b1_im"}, out_b1_im, b1i);
      check_eq({tag, "_ovf"},   {31'd0, out_ovf}, {31'd0, ovf});
   endtask

   task automatic finish_pair(input string tag);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check_eq({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_data = 32'd0; in_valid = 1'b0;
      out_ready = 1'b0; in_a0_re = 32'd0; in_a0_im = 32'd0; in_a1_re = 32'd0; in_a1_im = 32'd0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check_eq("rst_in_ready",  {31'd0, in_ready},  32'd1);
      check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check_eq("rst_busy",      {31'd0, busy},      32'd0);
      check_eq("rst_ovf",       {31'd0, out_ovf},   32'd0);
      check_eq("rst_b0_re",     out_b0_re,          32'd0);
      check_eq("rst_b1_im",     out_b1_im,          32'd0);

      // Identity after reset; result appears 16 edges after the accepting edge (cycle T+17)
      start_pair(32'h0000_8000, 32'd0, 32'h0000_4000, 32'h0000_1000);
      check_eq("ident_busy", {31'd0, busy}, 32'd1);
      wait_done(1'b0, lat);
      check_eq("ident_latency", lat, 32'd16);
      check_result("ident", 32'h0000_8000, 32'd0, 32'h0000_4000, 32'h0000_1000, 1'b0);
      finish_pair("ident");

      // Hadamard
      cfg_write(3'd0, 32'd46341); cfg_write(3'd2, 32'd46341);
      cfg_write(3'd4, 32'd46341); cfg_write(3'd6, 32'hFFFF_4AFB);
      start_pair(32'h0001_0000, 32'd0, 32'd0, 32'd0);
      wait_done(1'b0, lat);
      check_eq("had_latency", lat, 32'd16);
      check_result("had", 32'd46341, 32'd0, 32'd46341, 32'd0, 1'b0);
      finish_pair("had");

      // Pauli-Y
      cfg_write(3'd0, 32'd0); cfg_write(3'd2, 32'd0); cfg_write(3'd4, 32'd0); cfg_write(3'd6, 32'd0);
      cfg_write(3'd3, 32'hFFFF_0000); cfg_write(3'd5, 32'h0001_0000);
      start_pair(32'h0001_0000, 32'd0, 32'd0, 32'd0);
      wait_done(1'b0, lat);
      check_result("pauliy", 32'd0, 32'd0, 32'd0, 32'h0001_0000, 1'b0);
      finish_pair("pauliy");

      // Saturation: each b0_re product overflows, then the sum saturates too
      cfg_write(3'd0, 32'h7FFF_0000); cfg_write(3'd2, 32'h7FFF_0000);
      cfg_write(3'd3, 32'd0); cfg_write(3'd5, 32'd0); cfg_write(3'd6, 32'h0001_0000);
      start_pair(32'h0002_0000, 32'd0, 32'h0002_0000, 32'd0);
      wait_done(1'b0, lat);
      check_result("sat", 32'h7FFF_FFFF, 32'd0, 32'h0002_0000, 32'd0, 1'b1);
      finish_pair("sat");

      // Identity again with a mid-MAC cfg write that must be ignored, then backpressure
      cfg_write(3'd0, 32'h0001_0000); cfg_write(3'd2, 32'd0);
      start_pair(32'h0003_0000, 32'hFFFF_8000, 32'h0000_1234, 32'h0000_5678);
      wait_done(1'b1, lat);
      check_result("poke", 32'h0003_0000, 32'hFFFF_8000, 32'h0000_1234, 32'h0000_5678, 1'b0);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
         check_eq("bp_valid",    {31'd0, out_valid}, 32'd1);
         check_eq("bp_b0_re",    out_b0_re, 32'h0003_0000);
         check_eq("bp_b1_im",    out_b1_im, 32'h0000_5678);
      end
      finish_pair("bp");

      start_pair(32'h0000_7000, 32'h0000_2000, 32'd0, 32'd0);
      wait_done(1'b0, lat);
      check_result("after_poke", 32'h0000_7000, 32'h0000_2000, 32'd0, 32'd0, 1'b0);
      finish_pair("after_poke");

      // Reset at MAC step 8 reverts coefficients to identity
      cfg_write(3'd0, 32'h0002_0000);
      start_pair(32'h0000_5000, 32'h0000_0800, 32'd0, 32'd0);
      repeat (8) @(posedge clk);
      #1;
      check_eq("mid_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_eq("mrst_valid", {31'd0, out_valid}, 32'd0);
      check_eq("mrst_ready", {31'd0, in_ready},  32'd1);
      check_eq("mrst_busy",  {31'd0, busy},      32'd0);
      start_pair(32'h0000_5000, 32'h0000_0800, 32'd0, 32'd0);
      wait_done(1'b0, lat);
      check_eq("mrst_latency", lat, 32'd16);
      check_result("mrst", 32'h0000_5000, 32'h0000_0800, 32'd0, 32'd0, 1'b0);
      finish_pair("mrst");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
